stream_mux_nto1: RTL and testbench
==================================

STREAM_MUX_NTO1 -- requirements
Module: stream_mux_nto1

Interface
REQ-001 Parameter WORD_SIZE, default 16, SHALL set the data word width in bits (legal 1..64).
REQ-002 Parameter NUM_CH, default 4, SHALL set the input channel count (legal 2..16).
REQ-003 Parameter ARB_MODE, default 0, SHALL select arbitration: 0 = external select, 1 = round-robin.
REQ-004 Derived constant SEL_W = max(1, clog2(NUM_CH)) SHALL size all channel-index signals.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  SHALL be a synchronous, active-low reset.
REQ-007 in_data  input  NUM_CH*WORD_SIZE  SHALL carry packed words; channel i occupies bits [i*WORD_SIZE +: WORD_SIZE].
REQ-008 in_valid  input  NUM_CH  SHALL flag a valid word per channel.
REQ-009 in_last  input  NUM_CH  SHALL flag the final word of a packet per channel.
REQ-010 in_ready  output  NUM_CH  SHALL flag per-channel acceptance.
REQ-011 sel  input  SEL_W  SHALL name the requested channel (used only when ARB_MODE=0).
REQ-012 out_data  output  WORD_SIZE  SHALL carry the head word of the output buffer.
REQ-013 out_valid  output  1  SHALL flag out_data valid.
REQ-014 out_last  output  1  SHALL carry the last flag of the head word.
REQ-015 out_ch  output  SEL_W  SHALL carry the source channel index of the head word.
REQ-016 out_ready  input  1  SHALL flag downstream acceptance.
REQ-017 busy  output  1  SHALL be 1 whenever the FSM is LOCKED or the buffer is non-empty.

Function
REQ-018 A transfer SHALL occur on any edge where valid and ready are both 1 on the same port; no other event moves data.
REQ-019 The FSM SHALL have two states: IDLE and LOCKED.
REQ-020 In IDLE, ARB_MODE=0: if sel < NUM_CH and in_valid[sel]=1, the FSM SHALL register grant=sel and enter LOCKED; otherwise remain IDLE.
REQ-021 In IDLE, ARB_MODE=1: the FSM SHALL grant the first channel with in_valid=1 searching upward (wrapping) from rr_ptr+1, register grant, and enter LOCKED; with no valid input it remains IDLE.
REQ-022 in_ready SHALL be all-zero in IDLE; in LOCKED only in_ready[grant] may be 1, equal to (buffer count < 2).
REQ-023 sel and other channels' in_valid SHALL be ignored while LOCKED.
REQ-024 On an input transfer with in_last[grant]=1, the FSM SHALL return to IDLE next cycle and (ARB_MODE=1) set rr_ptr=grant.
REQ-025 Each packet SHALL therefore incur exactly one IDLE arbitration cycle before its first word transfers.
REQ-026 Accepted words SHALL be written with {data, last, grant} into a 2-entry FIFO buffer; out_* reflect the head entry.
REQ-027 Latency SHALL be one cycle: a word accepted on edge N is presented on out_data after edge N with out_valid=1.
REQ-028 Sustained throughput SHALL be one word per cycle while out_ready=1 and the granted channel holds valid.
REQ-029 Full buffer (count=2): in_ready SHALL be 0; simultaneous push and pop at count=1 SHALL leave count=1 and preserve order.
REQ-030 Empty buffer: out_valid SHALL be 0; out_data, out_last, out_ch SHALL be 0.
REQ-031 Output words SHALL never reorder, drop, or duplicate; a packet's words SHALL appear contiguously on out_*.

Reset
REQ-032 On an edge with reset_n=0: FSM=IDLE, buffer count=0, grant=0, rr_ptr=NUM_CH-1 (first round-robin grant favours channel 0).
REQ-033 During and after reset: in_ready=0, out_valid=0, out_data=0, out_last=0, out_ch=0, busy=0.
REQ-034 Reset mid-packet SHALL discard buffered words and the partial packet; no recovery of dropped words.

Structure
REQ-035 Package stream_mux_pkg SHALL hold the FSM state enum (IDLE, LOCKED) and ARB_MODE constants (ARB_SEL=0, ARB_RR=1).
REQ-036 The 2-entry buffer SHALL be a sub-module stream_fifo2, parametrised by entry width, with push/pop/count ports and the same clk/reset_n.

Verification
REQ-037 ARB_MODE=0, sel=2, ch2 sends 3 words 0xA001..0xA003 (last on third), out_ready=1 -> out_data A001,A002,A003 on consecutive cycles, out_ch=2, out_last only on A003.
REQ-038 ARB_MODE=1, all 4 channels continuously valid with 1-word packets -> grant order 0,1,2,3,0; each preceded by one IDLE cycle.
REQ-039 Mid-packet on ch1, sel changes to 3 and ch3 valid -> remaining ch1 words complete first; ch3 granted only after ch1 last.
REQ-040 out_ready=0 for 5 cycles during a 4-word packet -> exactly 2 words buffered, in_ready[grant]=0, no loss; release delivers all 4 in order.
REQ-041 reset_n=0 for one cycle mid-packet with 2 buffered -> next cycle out_valid=0, busy=0, in_ready=0; following round-robin grant is channel 0.
REQ-042 NUM_CH=3, ARB_MODE=0, sel=3 with all inputs valid -> FSM stays IDLE, in_ready=0, out_valid=0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the N-to-1 packet stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int ARB_SEL = 0;
    localparam int ARB_RR  = 1;

    function automatic int sel_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO; head_data reads as zero while empty.
module stream_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/stream_mux_nto1.sv
// Packet-granular N-to-1 stream mux: selects a channel per packet (external
// select or round-robin) and forwards its words through a 2-entry buffer.
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int NUM_CH    = 4,
    parameter int ARB_MODE  = ARB_SEL,
    localparam int SEL_W    = sel_width(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_CH*WORD_SIZE-1:0] in_data,
    input  logic [NUM_CH-1:0]           in_valid,
    input  logic [NUM_CH-1:0]           in_last,
    output logic [NUM_CH-1:0]           in_ready,
    input  logic [SEL_W-1:0]            sel,
    output logic [WORD_SIZE-1:0]        out_data,
    output logic                        out_valid,
    output logic                        out_last,
    output logic [SEL_W-1:0]            out_ch,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int NSEL    = 2 ** SEL_W;
    localparam int ENTRY_W = WORD_SIZE + 1 + SEL_W;

    state_t               state;
    logic [SEL_W-1:0]     grant;
    logic [SEL_W-1:0]     rr_ptr;
    logic [SEL_W-1:0]     rr_pick;
    logic                 rr_found;
    int unsigned          rr_idx;
    logic [NSEL-1:0]      valid_pad;
    logic [NSEL-1:0]      last_pad;
    logic [NSEL-1:0]      ready_pad;
    logic [WORD_SIZE-1:0] words [NSEL];
    logic [1:0]           count;
    logic                 grant_ready;
    logic                 in_xfer;
    logic                 pop;
    logic [ENTRY_W-1:0]   head;

    // Channel vectors are padded to a power of two so that an out-of-range
    // sel (or index) reads as an invalid, empty channel.
    always_comb begin
        valid_pad = '0;
        last_pad  = '0;
        for (int unsigned i = 0; i < NSEL; i++) begin
            words[i] = '0;
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            valid_pad[i] = in_valid[i];
            last_pad[i]  = in_last[i];
            words[i]     = in_data[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            rr_idx = 32'(rr_ptr) + k;
            if (rr_idx >= unsigned'(NUM_CH)) begin
                rr_idx = rr_idx - unsigned'(NUM_CH);
            end
            if (!rr_found && valid_pad[rr_idx[SEL_W-1:0]]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx[SEL_W-1:0];
            end
        end
    end

    assign grant_ready = (state == LOCKED) && (count < 2'd2);
    assign in_xfer     = grant_ready && valid_pad[grant];

    always_comb begin
        ready_pad        = '0;
        ready_pad[grant] = grant_ready;
        in_ready         = ready_pad[NUM_CH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= SEL_W'(NUM_CH - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (ARB_MODE == ARB_RR) begin
                        if (rr_found) begin
                            grant <= rr_pick;
                            state <= LOCKED;
                        end
                    end else if (valid_pad[sel]) begin
                        grant <= sel;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_xfer && last_pad[grant]) begin
                        state <= IDLE;
                        if (ARB_MODE == ARB_RR) begin
                            rr_ptr <= grant;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop = out_valid && out_ready;

    stream_fifo2 #(
        .WIDTH(ENTRY_W)
    ) u_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (in_xfer),
        .push_data({words[grant], last_pad[grant], grant}),
        .pop      (pop),
        .head_data(head),
        .count    (count)
    );

    assign out_valid = (count != 2'd0);
    assign out_data  = head[ENTRY_W-1 -: WORD_SIZE];
    assign out_last  = head[SEL_W];
    assign out_ch    = head[SEL_W-1:0];
    assign busy      = (state == LOCKED) || (count != 2'd0);

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Bench for stream_mux_nto1: three instances (select/4ch, round-robin/4ch,
// select/3ch) driven one at a time from per-channel packet queues.
module tb_stream_mux_nto1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          act;
    int          nch;
    logic [63:0] g_data;
    logic [3:0]  g_valid;
    logic [3:0]  g_last;
    logic [1:0]  g_sel;
    logic        g_ordy;

    logic [63:0] d0_data, d1_data;
    logic [47:0] d2_data;
    logic [3:0]  d0_valid, d0_last, d1_valid, d1_last;
    logic [2:0]  d2_valid, d2_last;
    logic [1:0]  d0_sel, d1_sel, d2_sel;
    logic        d0_ordy, d1_ordy, d2_ordy;
    logic [3:0]  rdy0, rdy1;
    logic [2:0]  rdy2;
    logic [15:0] od0, od1, od2;
    logic        ov0, ov1, ov2, ol0, ol1, ol2, bz0, bz1, bz2;
    logic [1:0]  och0, och1, och2;

    assign d0_data  = (act == 0) ? g_data : '0;
    assign d0_valid = (act == 0) ? g_valid : '0;
    assign d0_last  = (act == 0) ? g_last : '0;
    assign d0_sel   = (act == 0) ? g_sel : '0;
    assign d0_ordy  = (act == 0) ? g_ordy : 1'b0;
    assign d1_data  = (act == 1) ? g_data : '0;
    assign d1_valid = (act == 1) ? g_valid : '0;
    assign d1_last  = (act == 1) ? g_last : '0;
    assign d1_sel   = (act == 1) ? g_sel : '0;
    assign d1_ordy  = (act == 1) ? g_ordy : 1'b0;
    assign d2_data  = (act == 2) ? g_data[47:0] : '0;
    assign d2_valid = (act == 2) ? g_valid[2:0] : '0;
    assign d2_last  = (act == 2) ? g_last[2:0] : '0;
    assign d2_sel   = (act == 2) ? g_sel : '0;
    assign d2_ordy  = (act == 2) ? g_ordy : 1'b0;

    stream_mux_nto1 #(.WORD_SIZE(16), .NUM_CH(4), .ARB_MODE(0)) u_sel (
        .clk(clk), .reset_n(rst_n), .in_data(d0_data), .in_valid(d0_valid),
        .in_last(d0_last), .in_ready(rdy0), .sel(d0_sel), .out_data(od0),
        .out_valid(ov0), .out_last(ol0), .out_ch(och0), .out_ready(d0_ordy), .busy(bz0));

    stream_mux_nto1 #(.WORD_SIZE(16), .NUM_CH(4), .ARB_MODE(1)) u_rr (
        .clk(clk), .reset_n(rst_n), .in_data(d1_data), .in_valid(d1_valid),
        .in_last(d1_last), .in_ready(rdy1), .sel(d1_sel), .out_data(od1),
        .out_valid(ov1), .out_last(ol1), .out_ch(och1), .out_ready(d1_ordy), .busy(bz1));

    stream_mux_nto1 #(.WORD_SIZE(16), .NUM_CH(3), .ARB_MODE(0)) u_sel3 (
        .clk(clk), .reset_n(rst_n), .in_data(d2_data), .in_valid(d2_valid),
        .in_last(d2_last), .in_ready(rdy2), .sel(d2_sel), .out_data(od2),
        .out_valid(ov2), .out_last(ol2), .out_ch(och2), .out_ready(d2_ordy), .busy(bz2));

    logic [3:0]  m_rdy;
    logic [15:0] m_data;
    logic        m_valid, m_last, m_busy;
    logic [1:0]  m_ch;

    always_comb begin
        case (act)
            0: begin
                m_rdy = rdy0; m_data = od0; m_valid = ov0; m_last = ol0; m_ch = och0; m_busy = bz0;
            end
            1: begin
                m_rdy = rdy1; m_data = od1; m_valid = ov1; m_last = ol1; m_ch = och1; m_busy = bz1;
            end
            default: begin
                m_rdy = {1'b0, rdy2}; m_data = od2; m_valid = ov2; m_last = ol2; m_ch = och2; m_busy = bz2;
            end
        endcase
    end

    // Source word = {last, data}; expected output word = {ch, last, data}.
    logic [16:0] src_q [4][$];
    logic [16:0] stg   [4][$];
    logic [18:0] exp_q [$];
    bit          mid   [4];
    int          in_cycs [$];
    int          out_cycs[$];
    int          cyc, n_in, rr_model;
    bit          gaps, ordy_rand, ordy_val;
    int          compared, mismatched;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // mode: 0 = straight to expected list, 1 = staged for round-robin ordering, 2 = never delivered
    task automatic add_pkt(input int ch, input int len, input bit rnd, input logic [15:0] base, input int mode);
        logic [16:0] w;
        for (int i = 0; i < len; i++) begin
            w = {(i == len - 1), rnd ? 16'($urandom_range(0, 65535)) : 16'(base + 16'(i))};
            src_q[ch].push_back(w);
            if (mode == 0) exp_q.push_back({2'(ch), w});
            else if (mode == 1) stg[ch].push_back(w);
        end
    endtask

    // Whole packets are granted in cyclic order starting after the last granted channel.
    task automatic build_rr();
        bit          any;
        int          c;
        logic [16:0] w;
        do begin
            any = 0;
            for (int k = 1; k <= 4; k++) begin
                c = (rr_model + k) % 4;
                if (!any && stg[c].size() > 0) begin
                    do begin
                        w = stg[c].pop_front();
                        exp_q.push_back({2'(c), w});
                    end while (!w[16]);
                    rr_model = c;
                    any = 1;
                end
            end
        end while (any);
    endtask

    task automatic drive();
        g_valid = '0;
        g_last  = '0;
        g_data  = '0;
        for (int c = 0; c < nch; c++) begin
            if (src_q[c].size() > 0 && !(mid[c] && gaps && $urandom_range(0, 3) == 0)) begin
                g_valid[c] = 1'b1;
                g_last[c]  = src_q[c][0][16];
                g_data[c*16 +: 16] = src_q[c][0][15:0];
            end
        end
        g_ordy = ordy_rand ? ($urandom_range(0, 3) != 0) : ordy_val;
    endtask

    task automatic observe();
        logic [18:0] got;
        check("in_ready_onehot", 64'($countones(m_rdy) <= 1), 64'd1);
        for (int c = 0; c < nch; c++) begin
            if (g_valid[c] && m_rdy[c]) begin
                mid[c] = !src_q[c][0][16];
                void'(src_q[c].pop_front());
                n_in++;
                in_cycs.push_back(cyc);
            end
        end
        if (m_valid && g_ordy) begin
            got = {m_ch, m_last, m_data};
            check("out_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check("out_word", got, exp_q.pop_front());
            out_cycs.push_back(cyc);
        end
        if (!m_valid) check("empty_out_zero", {m_data, m_last, m_ch}, 64'd0);
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, exp_q.size(), 64'd0);
    endtask

    task automatic clear_sources();
        for (int c = 0; c < 4; c++) begin
            src_q[c].delete();
            stg[c].delete();
            mid[c] = 0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, start;
        compared = 0; mismatched = 0; cyc = 0; n_in = 0;
        act = 0; nch = 4; gaps = 0; ordy_rand = 0; ordy_val = 1;
        g_sel = '0; rr_model = 3; rst_n = 1'b0;
        clear_sources();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int d = 0; d < 3; d++) begin
            act = d;
            #1;
            check("rst_in_ready", m_rdy, 64'd0);
            check("rst_out_valid", m_valid, 64'd0);
            check("rst_busy", m_busy, 64'd0);
            check("rst_out_fields", {m_data, m_last, m_ch}, 64'd0);
        end
        act = 0;
        drive();

        // select mode: ch2, three words, full-rate output
        g_sel = 2'd2;
        in_cycs.delete(); out_cycs.delete();
        add_pkt(2, 3, 0, 16'hA001, 0);
        drive();
        start = cyc;
        drain("sel_basic", 20);
        check("sel_basic_in_count", in_cycs.size(), 64'd3);
        check("sel_basic_out_count", out_cycs.size(), 64'd3);
        if (in_cycs.size() > 0) check("sel_basic_arb_cycle", in_cycs[0], 64'(start + 1));
        for (int i = 0; i < out_cycs.size() && i < in_cycs.size(); i++) begin
            check("sel_basic_latency", out_cycs[i], 64'(in_cycs[i] + 1));
            check("sel_basic_throughput", out_cycs[i], 64'(out_cycs[0] + i));
        end

        // select changes mid-packet: ch1 must finish before ch3 is granted
        g_sel = 2'd1;
        add_pkt(1, 3, 1, 16'h0, 0);
        add_pkt(3, 2, 1, 16'h0, 0);
        drive();
        n0 = n_in;
        for (int i = 0; i < 10 && n_in == n0; i++) tick();
        g_sel = 2'd3;
        drain("sel_switch", 40);

        // back-pressure: buffer fills to two and stalls the source
        g_sel = 2'd1;
        ordy_val = 0;
        add_pkt(1, 4, 1, 16'h0, 0);
        drive();
        n0 = n_in;
        repeat (5) tick();
        check("stall_accepted", n_in - n0, 64'd2);
        check("stall_in_ready", m_rdy, 64'd0);
        check("stall_busy", m_busy, 64'd1);
        check("stall_out_valid", m_valid, 64'd1);
        ordy_val = 1;
        drive();
        drain("stall_release", 30);

        // three-channel instance: out-of-range select never grants
        act = 2; nch = 3; g_sel = 2'd3;
        add_pkt(0, 2, 1, 16'h0, 2);
        add_pkt(1, 2, 1, 16'h0, 0);
        add_pkt(2, 2, 1, 16'h0, 2);
        drive();
        repeat (4) begin
            tick();
            check("badsel_in_ready", m_rdy, 64'd0);
            check("badsel_out_valid", m_valid, 64'd0);
            check("badsel_busy", m_busy, 64'd0);
        end
        g_sel = 2'd1;
        drain("sel3_ch1", 20);
        clear_sources();
        drive();

        // round-robin with every channel continuously offering 1-word packets
        act = 1; nch = 4; g_sel = '0;
        in_cycs.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) add_pkt(c, 1, 1, 16'h0, 1);
        build_rr();
        drive();
        drain("rr_fair", 40);
        check("rr_fair_in_count", in_cycs.size(), 64'd8);
        for (int i = 1; i < in_cycs.size(); i++)
            check("rr_fair_spacing", in_cycs[i] - in_cycs[i-1], 64'd2);

        // round-robin random traffic with source gaps and random back-pressure
        gaps = 1; ordy_rand = 1;
        repeat (30) add_pkt($urandom_range(0, 3), $urandom_range(1, 4), 1, 16'h0, 1);
        build_rr();
        drive();
        drain("rr_random", 2000);

        // reset in the middle of a packet with two words buffered
        gaps = 0; ordy_rand = 0; ordy_val = 0;
        add_pkt(2, 4, 1, 16'h0, 2);
        drive();
        n0 = n_in;
        repeat (4) tick();
        check("rst_mid_buffered", n_in - n0, 64'd2);
        rst_n = 1'b0;
        clear_sources();
        drive();
        tick();
        rst_n = 1'b1;
        rr_model = 3;
        #1;
        check("rst_mid_out_valid", m_valid, 64'd0);
        check("rst_mid_busy", m_busy, 64'd0);
        check("rst_mid_in_ready", m_rdy, 64'd0);
        ordy_val = 1;
        for (int c = 0; c < 4; c++) add_pkt(c, 1, 1, 16'h0, 1);
        build_rr();
        check("rst_mid_first_grant_model", exp_q[0][18:17], 64'd0);
        drive();
        drain("rst_mid_after", 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
